// File: rtl/open_list_scheduler_if.sv
// Insert/pop handshake bundle of the A* open-list scheduler.
interface open_list_scheduler_if #(
   parameter int unsigned F_W    = 16,
   parameter int unsigned DATA_W = 32
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [F_W-1:0]    in_f;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [F_W-1:0]    out_f;
   logic [DATA_W-1:0] out_data;
   logic [4:0]        count;
   logic              empty;
   logic              full;

   modport slave (
      input  flush, in_valid, in_f, in_data, out_ready,
      output in_ready, out_valid, out_f, out_data, count, empty, full
   );

   modport master (
      output flush, in_valid, in_f, in_data, out_ready,
      input  in_ready, out_valid, out_f, out_data, count, empty, full
   );
endinterface

// File: rtl/open_list_scheduler.sv
// 16-entry A* open list: buffers inserted nodes and presents the minimum-f
// node through a registered strict-less-than scan (lowest index wins ties).
module open_list_scheduler #(
   parameter int unsigned F_W    = 16,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   open_list_scheduler_if.slave  bus
);
   localparam int unsigned DEPTH = 16;
   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {S_EMPTY, S_SETTLE, S_READY} state_t;

   state_t            state_q, state_d;
   logic [DEPTH-1:0]  valid_q;
   logic [F_W-1:0]    f_q    [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, empty_q;
   logic [IDX_W-1:0]  min_idx_q;
   logic [F_W-1:0]    min_f_q;
   logic [DATA_W-1:0] min_data_q;

   logic              in_ready_c, out_valid_c, ins, pop;
   logic [IDX_W-1:0]  free_idx;
   logic [DEPTH-1:0]  cand_vld;
   logic [F_W-1:0]    cand_f    [DEPTH];
   logic [DATA_W-1:0] cand_data [DEPTH];
   logic              scan_hit;
   logic [IDX_W-1:0]  scan_idx;
   logic [F_W-1:0]    scan_f;
   logic [DATA_W-1:0] scan_data;

   assign in_ready_c  = !full_q && !bus.flush;
   assign out_valid_c = (state_q == S_READY) && !bus.flush;
   assign ins         = bus.in_valid && in_ready_c;
   assign pop         = out_valid_c && bus.out_ready;

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_f     = min_f_q;
   assign bus.out_data  = min_data_q;
   assign bus.count     = count_q;
   assign bus.empty     = empty_q;
   assign bus.full      = full_q;

   // Lowest free slot, taken from the slot state before any same-cycle pop.
   always_comb begin
      free_idx = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = IDX_W'(i);
      end
   end

   // Scan candidates include the node being inserted this cycle, so a scan
   // registered while an insert lands is never missing that node.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         cand_vld[i]  = valid_q[i];
         cand_f[i]    = f_q[i];
         cand_data[i] = data_q[i];
         if (ins && (free_idx == IDX_W'(i))) begin
            cand_vld[i]  = 1'b1;
            cand_f[i]    = bus.in_f;
            cand_data[i] = bus.in_data;
         end
      end
   end

   always_comb begin
      scan_hit  = 1'b0;
      scan_idx  = '0;
      scan_f    = '0;
      scan_data = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (cand_vld[i] && (!scan_hit || (cand_f[i] < scan_f))) begin
            scan_hit  = 1'b1;
            scan_idx  = IDX_W'(i);
            scan_f    = cand_f[i];
            scan_data = cand_data[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (bus.flush) begin
         state_d = S_EMPTY;
         count_d = '0;
      end else begin
         count_d = count_q + CNT_W'(ins) - CNT_W'(pop);
         case (state_q)
            S_EMPTY:  if (ins) state_d = S_SETTLE;
            S_SETTLE: state_d = (count_d != '0) ? S_READY : S_EMPTY;
            S_READY:  if (ins || pop) state_d = (count_d == '0) ? S_EMPTY : S_SETTLE;
            default:  state_d = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_EMPTY;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // The insert never hits the popped slot: that slot is valid, the free one is not.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (bus.flush) begin
         valid_q <= '0;
      end else begin
         if (pop) valid_q[min_idx_q] <= 1'b0;
         if (ins) valid_q[free_idx]  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ins) begin
         f_q[free_idx]    <= bus.in_f;
         data_q[free_idx] <= bus.in_data;
      end
   end

   // Registered minimum; holds its value when nothing is valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         min_idx_q  <= '0;
         min_f_q    <= '0;
         min_data_q <= '0;
      end else if (scan_hit) begin
         min_idx_q  <= scan_idx;
         min_f_q    <= scan_f;
         min_data_q <= scan_data;
      end
   end
endmodule

// File: doc/open_list_scheduler.md
# open_list_scheduler

Sequencing controller that owns the 16-entry A* open list and drives the minimum-f selection datapath. It buffers candidate nodes from the neighbour-expansion stage and performs the 16-way strict-less-than minimum search over valid entries as a registered scan. It presents the current best node to the expansion controller over a valid/ready pop interface. It sits between the neighbour generator (insert side) and the expansion/closed-list logic (pop side).

## Interface
- F_W, default 16: width of the f cost key.
- DATA_W, default 32: width of the opaque node payload (coordinates, g, parent), stored and returned unchanged.
- DEPTH, fixed at 16: number of entries; not overridable.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the whole list; highest priority.
- in_valid  in  1  insert request.
- in_ready  out  1  asserted when the list is not full and flush is low.
- in_f  in  F_W  f key of the inserted node.
- in_data  in  DATA_W  payload of the inserted node.
- out_valid  out  1  the current minimum node is valid and stable.
- out_ready  in  1  consumer pops the presented node.
- out_f  out  F_W  f of the presented node.
- out_data  out  DATA_W  payload of the presented node.
- count  out  5  number of valid entries, 0..16.
- empty  out  1  count == 0.
- full  out  1  count == 16.

## Operation
- Storage: 16 slots, each holding valid, f and data.
- Insert: the handshake completes when in_valid && in_ready. The node is written to the lowest-index free slot, which is computed from the slot state before any same-cycle pop.
- Scan: each cycle a combinational search over valid slots finds the minimum f using strict less-than. On ties, the lowest index wins. The result (min_idx, min_f, min_data) is registered.
- FSM states:
  - EMPTY: count == 0, out_valid = 0.
  - SETTLE: registered scan is stale, out_valid = 0.
  - READY: out_valid = 1, outputs come from the registered scan.
- FSM transitions:
  - EMPTY, insert accepted → SETTLE.
  - SETTLE → READY if count > 0, else EMPTY. SETTLE always lasts exactly one cycle.
  - READY, pop and/or insert accepted → SETTLE, or EMPTY if the resulting count is 0.
  - READY, no handshake → READY.
  - Any state, flush → EMPTY.
- Pop: the handshake completes when out_valid && out_ready. It clears the valid bit of slot min_idx.
- Simultaneous insert and pop in READY: both take effect, and count is unchanged. The insert never targets the slot being popped in that cycle.
- Full: in_ready = 0 even if a pop occurs in the same cycle. There is no insert-through-pop.
- An accepted insert while in READY drops out_valid for the next cycle without a pop, because the new node may be smaller. The consumer must only act on a completed handshake.
- out_f and out_data hold their values while in READY without a handshake.
- Flush:
  - Clears all valid bits and sets count to 0.
  - Forces in_ready = 0 and out_valid = 0 in the flush cycle, so no handshake can complete during flush.
  - Stored f and data bits are don't-care after flush.
- count arithmetic: +1 on insert, −1 on pop, net 0 on both. It never wraps, guaranteed by in_ready and out_valid gating.

## Timing
- Reset values (asserted asynchronously while rst = 0):
  - all valid bits = 0, state = EMPTY;
  - out_valid = 0, out_f = 0, out_data = 0;
  - count = 0, empty = 1, full = 0;
  - in_ready = 1.
- Insert-to-present latency: insert accepted at edge t, SETTLE during cycle t+1, out_valid = 1 in cycle t+2.
- Pop-to-next latency: pop accepted at edge t, out_valid = 0 in cycle t+1, next minimum presented in cycle t+2.
- Pop throughput: one node every 2 cycles.
- in_ready, empty and full are derived from registered count and flush only, so there is no combinational path from out_ready to in_ready.
- Reset asserted mid-operation discards all entries immediately. Operation resumes in EMPTY on the first edge after rst rises.

## Test plan
- Reset, then insert f = 30, 10, 20 on consecutive cycles:
  - out_valid rises 2 cycles after the last insert with out_f = 10;
  - pops then return 10, 20, 30, each with a 1-cycle gap;
  - empty = 1 after the third pop.
- Tie-break: insert f = 5 with data 0xA into slot 0 and f = 5 with data 0xB into slot 1. The first pop returns data 0xA.
- Full:
  - 16 inserts give full = 1 and in_ready = 0;
  - a 17th in_valid is not accepted;
  - a pop in the same cycle as a 17th attempt leaves count = 15, and the node is not inserted.
- Simultaneous insert and pop in READY: count is unchanged. The popped slot is freed and the insert lands in the previous lowest free slot. The new min is correct 2 cycles later.
- Insert f = 1 while READY presents f = 9 with out_ready = 0: out_valid drops for 1 cycle, then returns with out_f = 1.
- Flush with count = 7 and in_valid = 1: count = 0, no insert accepted, out_valid = 0. Repeat with rst pulled low mid-stream and check all reset values.
